// File: rtl/except_flush_ctrl_pkg.sv
// Shared types for the exception/fence sequencing controller: cause codes,
// TLB flush types, control-unit operation tags and cause classification.
package except_flush_ctrl_pkg;

    localparam int unsigned EXCEPT_CODE_LEN = 4;

    // Synchronous exception causes (RISC-V mcause encoding, low 4 bits)
    typedef enum logic [EXCEPT_CODE_LEN-1:0] {
        E_I_ADDR_MISALIGNED   = 4'd0,
        E_I_ACCESS_FAULT      = 4'd1,
        E_ILLEGAL_INSTRUCTION = 4'd2,
        E_BREAKPOINT          = 4'd3,
        E_LD_ADDR_MISALIGNED  = 4'd4,
        E_LD_ACCESS_FAULT     = 4'd5,
        E_ST_ADDR_MISALIGNED  = 4'd6,
        E_ST_ACCESS_FAULT     = 4'd7,
        E_ENV_CALL_UMODE      = 4'd8,
        E_ENV_CALL_SMODE      = 4'd9,
        E_ENV_CALL_MMODE      = 4'd11,
        E_INSTR_PAGE_FAULT    = 4'd12,
        E_LD_PAGE_FAULT       = 4'd13,
        E_ST_PAGE_FAULT       = 4'd15
    } except_code_t;

    // TLB flush request kind
    typedef enum logic [1:0] {
        NoFlush   = 2'd0,
        FlushAll  = 2'd1,
        FlushASID = 2'd2
    } tlb_flush_t;

    // Operation currently being sequenced by the controller
    typedef enum logic [1:0] {
        OP_EXC    = 2'd0,
        OP_FENCEI = 2'd1,
        OP_SFENCE = 2'd2
    } cu_op_t;

    // Cause class: decides which MSHRs to clear and whether to sync L1D
    typedef enum logic [2:0] {
        EXC_I     = 3'd0,
        EXC_LS    = 3'd1,
        EXC_ILL   = 3'd2,
        EXC_ECALL = 3'd3,
        EXC_OTHER = 3'd4
    } exc_class_t;

    // Map a cause code onto its sequencing class. U-mode ecall needs no sync.
    function automatic exc_class_t classify(input except_code_t code);
        exc_class_t cls;
        case (code)
            E_INSTR_PAGE_FAULT,
            E_I_ADDR_MISALIGNED,
            E_I_ACCESS_FAULT:      cls = EXC_I;
            E_LD_PAGE_FAULT,
            E_LD_ADDR_MISALIGNED,
            E_LD_ACCESS_FAULT,
            E_ST_PAGE_FAULT,
            E_ST_ADDR_MISALIGNED,
            E_ST_ACCESS_FAULT:     cls = EXC_LS;
            E_ILLEGAL_INSTRUCTION: cls = EXC_ILL;
            E_ENV_CALL_SMODE,
            E_ENV_CALL_MMODE:      cls = EXC_ECALL;
            default:               cls = EXC_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/except_flush_ctrl_prio_arb.sv
// Fixed-priority exception arbiter: the lowest-index valid source wins and
// its index, cause code and PC are forwarded.
module exc_prio_arbiter
    import except_flush_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned XLEN  = 64,
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                           [N_SRC-1:0] valid_i,
    input  except_code_t                   [N_SRC-1:0] code_i,
    input  logic         [N_SRC-1:0][XLEN-1:0]         pc_i,
    output logic                                       valid_o,
    output logic                           [IDX_W-1:0] idx_o,
    output except_code_t                               code_o,
    output logic                            [XLEN-1:0] pc_o
);

    // Scan from the highest index down so the lowest valid index is the last write
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves one unassigned would infer a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        code_o  = E_I_ADDR_MISALIGNED;
        pc_o    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
                code_o  = code_i[i];
                pc_o    = pc_i[i];
            end
        end
    end

endmodule

// File: rtl/except_flush_ctrl.sv
// Exception and fence sequencing controller. Arbitrates exception sources and
// FENCE.I / SFENCE.VMA requests, then walks stall, drain, flush, MSHR clear,
// TLB flush and L1D->L2 sync handshakes before reporting a trap.
module except_flush_ctrl
    import except_flush_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ASID_LEN    = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                       [N_SRC-1:0] exc_valid_i,
    input  except_code_t               [N_SRC-1:0] exc_code_i,
    input  logic         [N_SRC-1:0][XLEN-1:0]     exc_pc_i,
    input  logic                                   fence_i_req_i,
    input  logic                                   sfence_req_i,
    input  logic                    [ASID_LEN-1:0] sfence_asid_i,
    input  logic                                   sfence_all_i,
    input  logic                                   commit_empty_i,
    input  logic                                   tlb_flush_ack_i,
    input  logic                                   l2c_update_done_i,
    output logic                                   busy_o,
    output logic                                   stall_o,
    output logic                                   flush_o,
    output logic                                   imshr_clr_o,
    output logic                                   dmshr_clr_o,
    output logic                                   tlb_flush_req_o,
    output tlb_flush_t                             tlb_flush_type_o,
    output logic                    [ASID_LEN-1:0] tlb_flush_asid_o,
    output logic                                   l1dc_sync_req_o,
    output logic                                   trap_valid_o,
    output except_code_t                           trap_code_o,
    output logic                        [XLEN-1:0] trap_pc_o,
    output logic                                   timeout_o
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam bit          TMO_EN = (TIMEOUT_CYC != 0);
    // Counter value during the last permitted waiting cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_FLUSH = 3'd2,
        S_TLB   = 3'd3,
        S_SYNC  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t                state_q;
    cu_op_t                op_q;
    exc_class_t            cls_q;
    except_code_t          code_q;
    logic     [XLEN-1:0]   pc_q;
    logic     [ASID_LEN-1:0] asid_q;
    logic                  all_q;
    logic     [CNT_W-1:0]  wait_cnt_q;
    logic                  timeout_q;

    logic                  win_valid;
    logic     [IDX_W-1:0]  win_idx;
    except_code_t          win_code;
    logic     [XLEN-1:0]   win_pc;
    logic                  timeout_hit;

    exc_prio_arbiter #(
        .N_SRC (N_SRC),
        .XLEN  (XLEN)
    ) u_prio_arb (
        .valid_i (exc_valid_i),
        .code_i  (exc_code_i),
        .pc_i    (exc_pc_i),
        .valid_o (win_valid),
        .idx_o   (win_idx),
        .code_o  (win_code),
        .pc_o    (win_pc)
    );

    assign timeout_hit = TMO_EN && (wait_cnt_q == CNT_LAST);

    // Sequencer: request arbitration, handshake waits and latched trap context
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            op_q       <= OP_EXC;
            cls_q      <= EXC_OTHER;
            code_q     <= E_I_ADDR_MISALIGNED;
            pc_q       <= '0;
            asid_q     <= '0;
            all_q      <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        op_q    <= OP_EXC;
                        code_q  <= win_code;
                        pc_q    <= win_pc;
                        cls_q   <= classify(win_code);
                        state_q <= S_FLUSH;
                    end else if (sfence_req_i) begin
                        op_q    <= OP_SFENCE;
                        asid_q  <= sfence_asid_i;
                        all_q   <= sfence_all_i;
                        state_q <= S_DRAIN;
                    end else if (fence_i_req_i) begin
                        op_q    <= OP_FENCEI;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (commit_empty_i) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    wait_cnt_q <= '0;
                    case (op_q)
                        OP_SFENCE: state_q <= S_TLB;
                        OP_FENCEI: state_q <= S_SYNC;
                        default:   state_q <= (cls_q == EXC_ECALL) ? S_SYNC : S_TRAP;
                    endcase
                end
                S_TLB: begin
                    if (tlb_flush_ack_i) begin
                        state_q <= S_IDLE;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_SYNC: begin
                    if (l2c_update_done_i || timeout_hit) begin
                        timeout_q <= !l2c_update_done_i;
                        state_q   <= (op_q == OP_EXC) ? S_TRAP : S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_TRAP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Design-intent check: the arbiter winner must be an asserted source
    always_ff @(posedge clk_i) begin
        if (rst_n_i && win_valid) begin
            assert (exc_valid_i[win_idx]);
        end
    end

    // Outputs are pure decodes of registered state
    assign busy_o           = (state_q != S_IDLE);
    assign stall_o          = busy_o;
    assign flush_o          = (state_q == S_FLUSH);
    assign imshr_clr_o      = flush_o && ((op_q == OP_SFENCE) || ((op_q == OP_EXC) && (cls_q == EXC_I)));
    assign dmshr_clr_o      = flush_o && ((op_q == OP_SFENCE) || ((op_q == OP_EXC) && (cls_q == EXC_LS)));
    assign tlb_flush_req_o  = (state_q == S_TLB);
    assign tlb_flush_type_o = !tlb_flush_req_o ? NoFlush : (all_q ? FlushAll : FlushASID);
    assign tlb_flush_asid_o = asid_q;
    assign l1dc_sync_req_o  = (state_q == S_SYNC);
    assign trap_valid_o     = (state_q == S_TRAP);
    assign trap_code_o      = code_q;
    assign trap_pc_o        = pc_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_except_flush_ctrl.sv
// Directed testbench for except_flush_ctrl (TIMEOUT_CYC overridden to 8).
module tb_except_flush_ctrl;
    import except_flush_ctrl_pkg::*;

    localparam int unsigned N_SRC    = 4;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned ASID_LEN = 16;

    logic                                clk_i = 1'b0;
    logic                                rst_n_i;
    logic                    [N_SRC-1:0] exc_valid_i;
    except_code_t            [N_SRC-1:0] exc_code_i;
    logic         [N_SRC-1:0][XLEN-1:0]  exc_pc_i;
    logic                                fence_i_req_i;
    logic                                sfence_req_i;
    logic                 [ASID_LEN-1:0] sfence_asid_i;
    logic                                sfence_all_i;
    logic                                commit_empty_i;
    logic                                tlb_flush_ack_i;
    logic                                l2c_update_done_i;
    logic                                busy_o;
    logic                                stall_o;
    logic                                flush_o;
    logic                                imshr_clr_o;
    logic                                dmshr_clr_o;
    logic                                tlb_flush_req_o;
    tlb_flush_t                          tlb_flush_type_o;
    logic                 [ASID_LEN-1:0] tlb_flush_asid_o;
    logic                                l1dc_sync_req_o;
    logic                                trap_valid_o;
    except_code_t                        trap_code_o;
    logic                     [XLEN-1:0] trap_pc_o;
    logic                                timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    except_flush_ctrl #(
        .N_SRC       (N_SRC),
        .XLEN        (XLEN),
        .ASID_LEN    (ASID_LEN),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .exc_valid_i       (exc_valid_i),
        .exc_code_i        (exc_code_i),
        .exc_pc_i          (exc_pc_i),
        .fence_i_req_i     (fence_i_req_i),
        .sfence_req_i      (sfence_req_i),
        .sfence_asid_i     (sfence_asid_i),
        .sfence_all_i      (sfence_all_i),
        .commit_empty_i    (commit_empty_i),
        .tlb_flush_ack_i   (tlb_flush_ack_i),
        .l2c_update_done_i (l2c_update_done_i),
        .busy_o            (busy_o),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .imshr_clr_o       (imshr_clr_o),
        .dmshr_clr_o       (dmshr_clr_o),
        .tlb_flush_req_o   (tlb_flush_req_o),
        .tlb_flush_type_o  (tlb_flush_type_o),
        .tlb_flush_asid_o  (tlb_flush_asid_o),
        .l1dc_sync_req_o   (l1dc_sync_req_o),
        .trap_valid_o      (trap_valid_o),
        .trap_code_o       (trap_code_o),
        .trap_pc_o         (trap_pc_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i           = 1'b0;
        exc_valid_i       = '0;
        for (int i = 0; i < N_SRC; i++) begin
            exc_code_i[i] = E_I_ADDR_MISALIGNED;
            exc_pc_i[i]   = '0;
        end
        fence_i_req_i     = 1'b0;
        sfence_req_i      = 1'b0;
        sfence_asid_i     = '0;
        sfence_all_i      = 1'b0;
        commit_empty_i    = 1'b0;
        tlb_flush_ack_i   = 1'b0;
        l2c_update_done_i = 1'b0;

        // ---- reset state ----
        #3;
        check("rst_busy",      64'(busy_o),           64'd0);
        check("rst_stall",     64'(stall_o),          64'd0);
        check("rst_tlb_type",  64'(tlb_flush_type_o), 64'(NoFlush));
        check("rst_trap_code", 64'(trap_code_o),      64'd0);
        check("rst_trap_pc",   64'(trap_pc_o),        64'd0);
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        check("idle_busy", 64'(busy_o), 64'd0);

        // ---- two sources, lowest index wins: LD page fault from src1 ----
        exc_code_i[1]  = E_LD_PAGE_FAULT;
        exc_pc_i[1]    = 64'h1000;
        exc_code_i[2]  = E_ILLEGAL_INSTRUCTION;
        exc_pc_i[2]    = 64'h2000;
        exc_valid_i    = 4'b0110;
        tick();
        exc_valid_i    = '0;
        check("ld_flush",     64'(flush_o),      64'd1);
        check("ld_dmshr",     64'(dmshr_clr_o),  64'd1);
        check("ld_imshr",     64'(imshr_clr_o),  64'd0);
        check("ld_stall",     64'(stall_o),      64'd1);
        check("ld_trap_early",64'(trap_valid_o), 64'd0);
        tick();
        check("ld_trap",      64'(trap_valid_o), 64'd1);
        check("ld_code",      64'(trap_code_o),  64'(E_LD_PAGE_FAULT));
        check("ld_pc",        trap_pc_o,         64'h1000);
        check("ld_flush_off", 64'(flush_o),      64'd0);
        tick();
        check("ld_idle",      64'(busy_o),       64'd0);
        check("ld_trap_off",  64'(trap_valid_o), 64'd0);

        // ---- M-mode ecall: sync held 5 cycles, then trap ----
        exc_code_i[0] = E_ENV_CALL_MMODE;
        exc_pc_i[0]   = 64'h3000;
        exc_valid_i   = 4'b0001;
        tick();
        exc_valid_i   = '0;
        check("ecall_flush", 64'(flush_o),     64'd1);
        check("ecall_imshr", 64'(imshr_clr_o), 64'd0);
        check("ecall_dmshr", 64'(dmshr_clr_o), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("ecall_sync_req", 64'(l1dc_sync_req_o), 64'd1);
            check("ecall_stall",    64'(stall_o),         64'd1);
            check("ecall_no_trap",  64'(trap_valid_o),    64'd0);
            if (i == 4) l2c_update_done_i = 1'b1;
            tick();
        end
        l2c_update_done_i = 1'b0;
        check("ecall_trap",     64'(trap_valid_o),    64'd1);
        check("ecall_sync_off", 64'(l1dc_sync_req_o), 64'd0);
        check("ecall_code",     64'(trap_code_o),     64'(E_ENV_CALL_MMODE));
        check("ecall_pc",       trap_pc_o,            64'h3000);
        check("ecall_no_tmo",   64'(timeout_o),       64'd0);
        tick();
        check("ecall_idle",     64'(busy_o),          64'd0);

        // ---- SFENCE.VMA ASID 0x2A, drain 3 cycles, ack after 2 ----
        sfence_req_i   = 1'b1;
        sfence_all_i   = 1'b0;
        sfence_asid_i  = 16'h002A;
        commit_empty_i = 1'b0;
        tick();
        sfence_req_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sf_drain_busy",  64'(busy_o),  64'd1);
            check("sf_drain_noflush", 64'(flush_o), 64'd0);
            if (i == 2) commit_empty_i = 1'b1;
            tick();
        end
        check("sf_flush", 64'(flush_o),     64'd1);
        check("sf_imshr", 64'(imshr_clr_o), 64'd1);
        check("sf_dmshr", 64'(dmshr_clr_o), 64'd1);
        tick();
        check("sf_tlb_req1",  64'(tlb_flush_req_o),  64'd1);
        check("sf_tlb_type",  64'(tlb_flush_type_o), 64'(FlushASID));
        check("sf_tlb_asid",  64'(tlb_flush_asid_o), 64'h2A);
        tick();
        check("sf_tlb_req2",  64'(tlb_flush_req_o),  64'd1);
        tlb_flush_ack_i = 1'b1;
        tick();
        tlb_flush_ack_i = 1'b0;
        check("sf_req_off",   64'(tlb_flush_req_o),  64'd0);
        check("sf_type_off",  64'(tlb_flush_type_o), 64'(NoFlush));
        check("sf_idle",      64'(busy_o),           64'd0);
        check("sf_no_trap",   64'(trap_valid_o),     64'd0);
        check("sf_no_tmo",    64'(timeout_o),        64'd0);

        // ---- exception beats simultaneous fences; fences held until idle ----
        exc_code_i[3]  = E_ILLEGAL_INSTRUCTION;
        exc_pc_i[3]    = 64'h4000;
        exc_valid_i    = 4'b1000;
        fence_i_req_i  = 1'b1;
        sfence_req_i   = 1'b1;
        sfence_all_i   = 1'b1;
        commit_empty_i = 1'b1;
        tick();
        exc_valid_i    = '0;
        check("pri_flush", 64'(flush_o),     64'd1);
        check("pri_imshr", 64'(imshr_clr_o), 64'd0);
        check("pri_dmshr", 64'(dmshr_clr_o), 64'd0);
        tick();
        check("pri_trap",  64'(trap_valid_o), 64'd1);
        check("pri_code",  64'(trap_code_o),  64'(E_ILLEGAL_INSTRUCTION));
        check("pri_pc",    trap_pc_o,         64'h4000);
        tick();
        check("pri_idle",  64'(busy_o),       64'd0);
        tick();
        fence_i_req_i  = 1'b0;
        sfence_req_i   = 1'b0;
        check("pri_sf_drain", 64'(busy_o),  64'd1);
        check("pri_sf_noflush", 64'(flush_o), 64'd0);
        tick();
        check("pri_sf_imshr", 64'(imshr_clr_o), 64'd1);
        check("pri_sf_dmshr", 64'(dmshr_clr_o), 64'd1);
        tick();

        // ---- TLB timeout: no ack for 8 waiting cycles ----
        check("tmo_type", 64'(tlb_flush_type_o), 64'(FlushAll));
        for (int i = 0; i < 8; i++) begin
            check("tmo_req_held", 64'(tlb_flush_req_o), 64'd1);
            check("tmo_not_yet",  64'(timeout_o),       64'd0);
            tick();
        end
        check("tmo_pulse",   64'(timeout_o),       64'd1);
        check("tmo_req_off", 64'(tlb_flush_req_o), 64'd0);
        check("tmo_idle",    64'(busy_o),          64'd0);
        tick();
        check("tmo_pulse_end", 64'(timeout_o), 64'd0);

        // ---- ack in the same cycle the timeout would fire counts as ack ----
        sfence_req_i  = 1'b1;
        sfence_all_i  = 1'b0;
        sfence_asid_i = 16'h0055;
        tick();
        sfence_req_i  = 1'b0;
        tick();
        tick();
        check("edge_asid", 64'(tlb_flush_asid_o), 64'h55);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) tlb_flush_ack_i = 1'b1;
            tick();
        end
        tlb_flush_ack_i = 1'b0;
        check("edge_no_tmo", 64'(timeout_o), 64'd0);
        check("edge_idle",   64'(busy_o),    64'd0);

        // ---- FENCE.I with ROB already empty: flush at t+2, sync, no trap ----
        fence_i_req_i = 1'b1;
        tick();
        fence_i_req_i = 1'b0;
        check("fi_drain_noflush", 64'(flush_o), 64'd0);
        tick();
        check("fi_flush",  64'(flush_o),     64'd1);
        check("fi_imshr",  64'(imshr_clr_o), 64'd0);
        check("fi_dmshr",  64'(dmshr_clr_o), 64'd0);
        tick();
        check("fi_sync",   64'(l1dc_sync_req_o), 64'd1);
        l2c_update_done_i = 1'b1;
        tick();
        l2c_update_done_i = 1'b0;
        check("fi_idle",    64'(busy_o),       64'd0);
        check("fi_no_trap", 64'(trap_valid_o), 64'd0);

        // ---- asynchronous reset in the middle of SYNC ----
        exc_code_i[0] = E_ENV_CALL_SMODE;
        exc_pc_i[0]   = 64'h5000;
        exc_valid_i   = 4'b0001;
        tick();
        exc_valid_i   = '0;
        tick();
        check("rs_sync_pre", 64'(l1dc_sync_req_o), 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rs_sync_off", 64'(l1dc_sync_req_o),  64'd0);
        check("rs_busy",     64'(busy_o),           64'd0);
        check("rs_stall",    64'(stall_o),          64'd0);
        check("rs_code",     64'(trap_code_o),      64'd0);
        check("rs_pc",       trap_pc_o,             64'd0);
        check("rs_asid",     64'(tlb_flush_asid_o), 64'd0);
        check("rs_type",     64'(tlb_flush_type_o), 64'(NoFlush));
        tick();
        rst_n_i = 1'b1;
        tick();
        check("rs_release_idle", 64'(busy_o),          64'd0);
        check("rs_release_sync", 64'(l1dc_sync_req_o), 64'd0);
        check("rs_release_trap", 64'(trap_valid_o),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/except_flush_ctrl.md
# except_flush_ctrl

Parametrised exception and fence sequencing controller for the LEN5 control unit. It arbitrates up to N_SRC simultaneous exception sources plus FENCE.I and SFENCE.VMA requests. For the winning request it runs the required sequence: pipeline stall, drain, flush, MSHR clears, TLB flush handshake, L1D→L2 sync handshake, trap report. It sits between the backend (ROB/commit, exception sources) and the memory subsystem (TLBs, MSHRs, L1D/L2), and replaces the ad-hoc per-cause output logic with handshaked, timeout-guarded sequencing.

## Interface
- N_SRC, 4: number of exception sources; index 0 has highest priority.
- XLEN, 64: PC width.
- ASID_LEN, 16: ASID width.
- TIMEOUT_CYC, 255: maximum wait cycles in TLB/SYNC. 0 disables the timeout.
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_n_i).
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- exc_valid_i  in  N_SRC  per-source exception request
- exc_code_i  in  N_SRC×except_code_t  per-source cause
- exc_pc_i  in  N_SRC×XLEN  per-source faulting PC
- fence_i_req_i  in  1  FENCE.I at commit
- sfence_req_i  in  1  SFENCE.VMA at commit
- sfence_asid_i  in  ASID_LEN  target ASID
- sfence_all_i  in  1  rs2==x0: flush all ASIDs
- commit_empty_i  in  1  ROB drained
- tlb_flush_ack_i  in  1  TLBs finished flush
- l2c_update_done_i  in  1  L1D→L2 sync finished
- busy_o  out  1  controller not IDLE
- stall_o  out  1  stall front end
- flush_o  out  1  one-cycle pipeline flush
- imshr_clr_o  out  1  one-cycle clear of L1/L2 TLB MSHRs (I-side)
- dmshr_clr_o  out  1  one-cycle clear of D-MSHR and D-regs
- tlb_flush_req_o  out  1  level request to TLBs
- tlb_flush_type_o  out  tlb_flush_t  NoFlush/FlushAll/FlushASID
- tlb_flush_asid_o  out  ASID_LEN  ASID for FlushASID
- l1dc_sync_req_o  out  1  level request to sync L1D with L2
- trap_valid_o  out  1  one-cycle trap report to CSR unit
- trap_code_o  out  except_code_t  latched cause
- trap_pc_o  out  XLEN  latched PC
- timeout_o  out  1  one-cycle pulse, handshake abandoned

## Operation
- States: IDLE, DRAIN, FLUSH, TLB, SYNC, TRAP.
- IDLE: an exception beats sfence, which beats fence.i.
  - Any exc_valid_i set: latch the lowest-index source's code and PC, go to FLUSH.
  - Else sfence_req_i: latch ASID/all, go to DRAIN.
  - Else fence_i_req_i: go to DRAIN.
- Requests arriving while busy_o=1 are ignored. Sources hold them until busy_o falls.
- DRAIN: wait for commit_empty_i=1, then go to FLUSH.
- FLUSH: flush_o=1 for one cycle, plus the cause-dependent clear pulse:
  - I-side causes (instr page fault, I misaligned, I access fault): imshr_clr_o.
  - LD/ST causes (page fault, misaligned, access fault): dmshr_clr_o.
  - sfence: imshr_clr_o and dmshr_clr_o.
  - Illegal instruction, ecall, fence.i: no clear.
- Next state after FLUSH: sfence → TLB; ecall S/M or fence.i → SYNC; other exceptions → TRAP.
- TLB: hold tlb_flush_req_o, type FlushAll if all else FlushASID, until tlb_flush_ack_i, then go to IDLE.
- SYNC: hold l1dc_sync_req_o until l2c_update_done_i. Then go to TRAP if an exception is latched, else IDLE.
- TRAP: trap_valid_o=1 for one cycle, then go to IDLE.
- stall_o = busy_o = (state≠IDLE).
- Timeout:
  - A wait counter is cleared on entry to TLB/SYNC and incremented every waiting cycle.
  - When it reaches TIMEOUT_CYC with no ack: pulse timeout_o, drop the request, take the ack-path transition.
  - An ack arriving in the same cycle as the timeout counts as an ack, with no timeout_o.
- Reset, including mid-sequence: state IDLE. All outputs 0, tlb_flush_type_o=NoFlush, latched code/PC/ASID 0, counter 0. Pending handshakes are abandoned.

## Timing
- Exception sampled in IDLE at cycle t: flush_o at t+1, trap_valid_o at t+2 (no sync).
- ecall with done at cycle k≥t+2: trap_valid_o at k+1.
- Fence with commit_empty_i already 1 at t+1: flush_o at t+2.
- tlb_flush_req_o and l1dc_sync_req_o rise the cycle after FLUSH and fall the cycle after the ack.
- All outputs are registered-state decodes; there is no combinational path from any input to any output.

## Structure
- Shared package (csr_pkg/memory_pkg):
  - except_code_t and tlb_flush_t, which already exist.
  - new cu_op_t {OP_EXC, OP_FENCEI, OP_SFENCE}.
  - new exc_class_t {EXC_I, EXC_LS, EXC_ILL, EXC_ECALL, EXC_OTHER} with classify function.
- Sub-module exc_prio_arbiter: fixed-priority lowest-index encoder; outputs valid, index, code, PC.

## Test plan
- exc_valid_i=4'b0110, src1=E_LD_PAGE_FAULT pc=0x1000, src2=E_ILLEGAL_INSTRUCTION -> flush_o+dmshr_clr_o at t+1; trap_code=E_LD_PAGE_FAULT, trap_pc=0x1000 at t+2.
- E_ENV_CALL_MMODE, l2c_update_done_i after 5 cycles -> l1dc_sync_req_o high 5 cycles, trap_valid_o the next cycle, stall_o high throughout.
- sfence_req_i, sfence_all_i=0, ASID=0x2A, commit_empty_i low 3 cycles -> DRAIN 3 cycles, flush+imshr+dmshr pulse, FlushASID 0x2A held until ack, no trap.
- Simultaneous fence_i_req_i, sfence_req_i and exc_valid_i[3] -> exception serviced, fences ignored until busy_o falls.
- TIMEOUT_CYC=8, no tlb_flush_ack_i -> timeout_o pulse after 8 waiting cycles, return to IDLE.
- rst_n_i low mid-SYNC -> all outputs 0 asynchronously; IDLE on release.
